// File: rtl/tx_mac_feed.sv
// tx_mac_feed: streams framed qwords from the ibuf ring to an AXI-Stream MAC
// through a 2-entry output buffer, and publishes the consumer index.
module tx_mac_feed #(
    parameter int BW = 9
) (
    input  logic          clk,
    input  logic          rst,
    output logic [BW-1:0] rd_addr,
    input  logic [63:0]   rd_data,
    output logic [BW:0]   committed_cons,
    input  logic          trig,
    input  logic [12:0]   qw_len,
    input  logic [7:0]    lst_ben,
    input  logic          rsk,
    output logic          rsk_tk,
    output logic          sync,
    output logic [63:0]   m_axis_tdata,
    output logic [7:0]    m_axis_tkeep,
    output logic          m_axis_tvalid,
    output logic          m_axis_tlast,
    input  logic          m_axis_tready
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        LATCH,
        HDR,
        DATA,
        SYNC
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] addr_q, addr_d;
    logic [BW:0]   cons_q, cons_d;
    logic [12:0]   len_q, len_d;
    logic [7:0]    ben_q, ben_d;
    logic [12:0]   rem_q, rem_d;
    logic          wait_q, wait_d;
    logic          infl_q, infl_d;
    logic          infl_last_q, infl_last_d;
    logic [1:0]    occ_q, occ_d;
    logic          head_q, head_d;
    logic [63:0]   buf_data_q [2];
    logic [63:0]   buf_data_d [2];
    logic [7:0]    buf_keep_q [2];
    logic [7:0]    buf_keep_d [2];
    logic          buf_last_q [2];
    logic          buf_last_d [2];

    logic          tvalid;
    logic          pop;
    logic          wr_idx;
    logic [1:0]    occ_left;
    logic [1:0]    pend;
    logic          can_issue;

    assign tvalid    = (occ_q != 2'd0);
    assign pop       = tvalid && m_axis_tready;
    assign wr_idx    = head_q ^ occ_q[0];
    // A beat leaving this cycle frees its slot for a read issued now
    assign occ_left  = occ_q - {1'b0, pop};
    assign pend      = occ_left + {1'b0, infl_q};
    assign can_issue = (rem_q != 13'd0) && (pend < 2'd2);

    assign rd_addr        = addr_q;
    assign committed_cons = cons_q;
    assign m_axis_tvalid  = tvalid;
    assign m_axis_tdata   = tvalid ? buf_data_q[head_q] : 64'd0;
    assign m_axis_tkeep   = tvalid ? buf_keep_q[head_q] : 8'd0;
    assign m_axis_tlast   = tvalid && buf_last_q[head_q];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cons_d      = cons_q;
        len_d       = len_q;
        ben_d       = ben_q;
        rem_d       = rem_q;
        wait_d      = wait_q;
        infl_d      = 1'b0;
        infl_last_d = 1'b0;
        rsk_tk      = 1'b0;
        sync        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    len_d   = qw_len;
                    ben_d   = lst_ben;
                    state_d = HDR;
                end else if (rsk) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                rsk_tk  = 1'b1;
                state_d = LATCH;
            end
            LATCH: begin
                len_d   = qw_len;
                ben_d   = lst_ben;
                state_d = HDR;
            end
            HDR: begin
                addr_d = addr_q + BW'(1);
                rem_d  = len_q;
                if (len_q == 13'd0) begin
                    // Header-only frame: header qword is consumed here,
                    // and one settle cycle lets rd_data catch up
                    cons_d  = cons_q + (BW+1)'(1);
                    wait_d  = 1'b1;
                    state_d = SYNC;
                end else begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (can_issue) begin
                    addr_d      = addr_q + BW'(1);
                    rem_d       = rem_q - 13'd1;
                    infl_d      = 1'b1;
                    infl_last_d = (rem_q == 13'd1);
                end
                if (pop && buf_last_q[head_q]) begin
                    cons_d  = cons_q + (BW+1)'(len_q) + (BW+1)'(1);
                    state_d = SYNC;
                end
            end
            SYNC: begin
                if (wait_q) begin
                    wait_d = 1'b0;
                end else begin
                    sync    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        buf_data_d = buf_data_q;
        buf_keep_d = buf_keep_q;
        buf_last_d = buf_last_q;
        if (infl_q) begin
            buf_data_d[wr_idx] = rd_data;
            buf_keep_d[wr_idx] = infl_last_q ? ben_q : 8'hFF;
            buf_last_d[wr_idx] = infl_last_q;
        end
        occ_d  = occ_q + {1'b0, infl_q} - {1'b0, pop};
        head_d = head_q ^ pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cons_q      <= '0;
            len_q       <= '0;
            ben_q       <= '0;
            rem_q       <= '0;
            wait_q      <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            occ_q       <= '0;
            head_q      <= 1'b0;
            buf_data_q  <= '{default: '0};
            buf_keep_q  <= '{default: '0};
            buf_last_q  <= '{default: 1'b0};
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cons_q      <= cons_d;
            len_q       <= len_d;
            ben_q       <= ben_d;
            rem_q       <= rem_d;
            wait_q      <= wait_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            occ_q       <= occ_d;
            head_q      <= head_d;
            buf_data_q  <= buf_data_d;
            buf_keep_q  <= buf_keep_d;
            buf_last_q  <= buf_last_d;
        end
    end

endmodule

// File: tb/tb_tx_mac_feed.sv
// tb_tx_mac_feed: directed frames against an ibuf model, with a beat
// recorder and hand-computed addresses, keeps and consumer indices.
module tb_tx_mac_feed;

    logic        clk;
    logic        rst;
    logic [8:0]  rd_addr;
    logic [63:0] rd_data;
    logic [9:0]  committed_cons;
    logic        trig;
    logic [12:0] qw_len;
    logic [7:0]  lst_ben;
    logic        rsk;
    logic        rsk_tk;
    logic        sync;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid;
    logic        tlast;
    logic        tready;

    int n_chk;
    int n_err;

    tx_mac_feed #(.BW(9)) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .committed_cons (committed_cons),
        .trig           (trig),
        .qw_len         (qw_len),
        .lst_ben        (lst_ben),
        .rsk            (rsk),
        .rsk_tk         (rsk_tk),
        .sync           (sync),
        .m_axis_tdata   (tdata),
        .m_axis_tkeep   (tkeep),
        .m_axis_tvalid  (tvalid),
        .m_axis_tlast   (tlast),
        .m_axis_tready  (tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] mdata(input int a);
        return 64'hBEEF_0000_0000_0000 + 64'(a) * 64'h0000_0001_0001;
    endfunction

    always @(posedge clk) rd_data <= mdata(int'(rd_addr));

    logic [63:0] bd [0:2047];
    logic [7:0]  bk [0:2047];
    logic        bl [0:2047];
    int          bc [0:2047];
    int          beat_cnt;
    int          last_cnt;
    int          sync_cnt;
    int          rsk_cnt;
    int          stall_bad;
    int          cyc;
    bit          stall_q;
    logic [63:0] sd;
    logic [7:0]  sk;
    logic        sl;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            stall_q <= 1'b0;
        end else begin
            if (sync) sync_cnt <= sync_cnt + 1;
            if (rsk_tk) rsk_cnt <= rsk_cnt + 1;
            if (stall_q && !(tvalid && tdata == sd && tkeep == sk && tlast == sl))
                stall_bad <= stall_bad + 1;
            stall_q <= tvalid && !tready;
            sd <= tdata;
            sk <= tkeep;
            sl <= tlast;
            if (tvalid && tready && beat_cnt < 2048) begin
                bd[beat_cnt] <= tdata;
                bk[beat_cnt] <= tkeep;
                bl[beat_cnt] <= tlast;
                bc[beat_cnt] <= cyc;
                if (tlast) last_cnt <= last_cnt + 1;
                beat_cnt <= beat_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fire(input int len, input logic [7:0] ben);
        @(negedge clk);
        qw_len  = 13'(len);
        lst_ben = ben;
        trig    = 1'b1;
        @(posedge clk);
        #1 trig = 1'b0;
    endtask

    task automatic wait_sync(input string tag, input bit toggle);
        int  base;
        bit  seen;
        base = sync_cnt;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (toggle) tready = ~tready;
            if (sync_cnt != base) seen = 1'b1;
        end
        tready = 1'b1;
        chk({tag, "_sync_seen"}, 64'(seen), 64'd1);
        repeat (3) @(posedge clk);
        #1 chk({tag, "_sync_cnt"}, 64'(sync_cnt - base), 64'd1);
    endtask

    task automatic check_frame(input string tag, input int base, input int n_exp,
                               input int a0, input logic [7:0] ben);
        int n;
        int bad_d;
        int bad_k;
        int bad_l;
        n = beat_cnt - base;
        bad_d = 0;
        bad_k = 0;
        bad_l = 0;
        chk({tag, "_beats"}, 64'(n), 64'(n_exp));
        for (int i = 0; i < n && i < n_exp; i++) begin
            if (bd[base+i] !== mdata((a0 + i) % 512)) bad_d++;
            if (bk[base+i] !== ((i == n_exp - 1) ? ben : 8'hFF)) bad_k++;
            if (bl[base+i] !== (i == n_exp - 1)) bad_l++;
        end
        chk({tag, "_data_errs"}, 64'(bad_d), 64'd0);
        chk({tag, "_keep_errs"}, 64'(bad_k), 64'd0);
        chk({tag, "_last_errs"}, 64'(bad_l), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int lbase;
        int rbase;
        int lat;
        rst     = 1'b1;
        trig    = 1'b0;
        rsk     = 1'b0;
        qw_len  = '0;
        lst_ben = '0;
        tready  = 1'b1;
        #1;
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_cons", 64'(committed_cons), 64'd0);
        chk("rst_tvalid", 64'(tvalid), 64'd0);
        chk("rst_tlast", 64'(tlast), 64'd0);
        chk("rst_tkeep", 64'(tkeep), 64'd0);
        chk("rst_tdata", tdata, 64'd0);
        chk("rst_sync_rsk", 64'({sync, rsk_tk}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 8-beat frame from address 0, tready held high
        base = beat_cnt;
        fire(8, 8'hFF);
        lat = 0;
        for (int i = 0; i < 10 && !tvalid; i++) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk("f8_first_valid_lat", 64'(lat), 64'd3);
        wait_sync("f8", 1'b0);
        check_frame("f8", base, 8, 1, 8'hFF);
        chk("f8_back_to_back", 64'(bc[base+7] - bc[base]), 64'd7);
        chk("f8_rd_addr", 64'(rd_addr), 64'd9);
        chk("f8_cons", 64'(committed_cons), 64'd9);

        // single-beat frame with partial keep
        base = beat_cnt;
        fire(1, 8'h07);
        wait_sync("f1", 1'b0);
        check_frame("f1", base, 1, 10, 8'h07);
        chk("f1_rd_addr", 64'(rd_addr), 64'd11);
        chk("f1_cons", 64'(committed_cons), 64'd11);

        // tready toggling every cycle
        base = beat_cnt;
        fire(5, 8'hFF);
        wait_sync("f5t", 1'b1);
        check_frame("f5t", base, 5, 12, 8'hFF);
        chk("f5t_stall_stable_errs", 64'(stall_bad), 64'd0);
        chk("f5t_rd_addr", 64'(rd_addr), 64'd17);
        chk("f5t_cons", 64'(committed_cons), 64'd17);

        // rsk launch: length is only presented after rsk_tk
        base = beat_cnt;
        rbase = rsk_cnt;
        @(negedge clk);
        qw_len = 13'd7;
        lst_ben = 8'h01;
        rsk = 1'b1;
        @(posedge clk);
        #1 chk("rsk_tk_pulse", 64'(rsk_tk), 64'd1);
        rsk = 1'b0;
        qw_len = 13'd3;
        lst_ben = 8'h3F;
        wait_sync("rsk", 1'b0);
        chk("rsk_tk_cnt", 64'(rsk_cnt - rbase), 64'd1);
        check_frame("rsk", base, 3, 18, 8'h3F);
        chk("rsk_rd_addr", 64'(rd_addr), 64'd21);
        chk("rsk_cons", 64'(committed_cons), 64'd21);

        // reset while beat 3 of 8 is presented
        base = beat_cnt;
        lbase = last_cnt;
        fire(8, 8'hFF);
        for (int i = 0; i < 50 && (beat_cnt - base) < 2; i++) @(posedge clk);
        #1;
        chk("mid_beats_before", 64'(beat_cnt - base), 64'd2);
        chk("mid_tvalid_before", 64'(tvalid), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_tvalid", 64'(tvalid), 64'd0);
        chk("mid_rd_addr", 64'(rd_addr), 64'd0);
        chk("mid_cons", 64'(committed_cons), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("mid_no_tlast", 64'(last_cnt - lbase), 64'd0);
        base = beat_cnt;
        fire(2, 8'h0F);
        wait_sync("resume", 1'b0);
        check_frame("resume", base, 2, 1, 8'h0F);
        chk("resume_rd_addr", 64'(rd_addr), 64'd3);
        chk("resume_cons", 64'(committed_cons), 64'd3);

        // ring wrap: move to 510, then a 4-qword frame crossing zero
        do_reset();
        base = beat_cnt;
        fire(509, 8'hFF);
        wait_sync("pre", 1'b0);
        check_frame("pre", base, 509, 1, 8'hFF);
        chk("pre_rd_addr", 64'(rd_addr), 64'd510);
        chk("pre_cons", 64'(committed_cons), 64'd510);
        base = beat_cnt;
        fire(4, 8'h0F);
        wait_sync("wrap", 1'b0);
        check_frame("wrap", base, 4, 511, 8'h0F);
        chk("wrap_rd_addr", 64'(rd_addr), 64'd3);
        chk("wrap_cons", 64'(committed_cons), 64'd515);
        chk("all_stall_stable_errs", 64'(stall_bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
